rb_frame_sequencer: RTL and testbench

Frame-level controller for the row-buffer BRAM datapath in neighborhood image processing. It walks the external image memory in raster order, primes the K-1 BRAM row buffers, then streams one K-row pixel column per beat. During streaming it reads all row buffers, overwrites the oldest buffer with the incoming pixel, and drives the steer rotation so the steering network presents rows oldest-first. It replaces ad-hoc enable sequencing with an explicit state machine that supports downstream throttling and reset.

---
 rtl/rb_frame_sequencer_pkg.sv | 27 ++
 rtl/rb_frame_sequencer_raster.sv | 66 ++++++
 rtl/rb_frame_sequencer.sv | 152 +++++++++++++++
 tb/tb_rb_frame_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rb_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rb_frame_sequencer_pkg
// Purpose  : Shared defaults, state encoding and width helper for the
//            row-buffer frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rb_frame_sequencer_pkg;

  // Default frame geometry: K-row window over an IMG_W x IMG_H image
  localparam int DEF_K     = 3;
  localparam int DEF_IMG_W = 8;
  localparam int DEF_IMG_H = 8;

  // Controller state encoding
  localparam logic [1:0] C_ST_IDLE   = 2'd0;
  localparam logic [1:0] C_ST_PRIME  = 2'd1;
  localparam logic [1:0] C_ST_STREAM = 2'd2;
  localparam logic [1:0] C_ST_DONE   = 2'd3;

  // Buffer-select width; a single row buffer still needs a 1-bit select port
  function automatic int sel_width(input int k);
    return (k > 2) ? $clog2(k - 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rb_frame_sequencer_raster.sv
`default_nettype none
// ============================================================================
// Module   : rb_raster_counter
// Purpose  : Raster position tracker: column, row, current row-buffer select
//            and linear pixel address, all advancing together on one beat.
// Revision : 1.0 - initial release
// ============================================================================
module rb_raster_counter #(
  parameter int IMG_W  = 8,
  parameter int K      = 3,
  parameter int COL_W  = $clog2(IMG_W),
  parameter int ROW_W  = 3,
  parameter int SEL_W  = 1,
  parameter int EMEM_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [SEL_W-1:0]  sel,
  output logic [EMEM_W-1:0] addr,
  output logic              row_end
);

  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [SEL_W-1:0] C_SEL_LAST = SEL_W'(K - 2);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [SEL_W-1:0]  r_sel;
  logic [EMEM_W-1:0] r_addr;

  // Position registers; clear wins so the final beat of a frame returns to origin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_sel  <= '0;
      r_addr <= '0;
    end else if (clear) begin
      r_col  <= '0;
      r_row  <= '0;
      r_sel  <= '0;
      r_addr <= '0;
    end else if (advance) begin
      r_addr <= r_addr + 1'b1;
      if (r_col == C_COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
        r_sel <= (r_sel == C_SEL_LAST) ? '0 : r_sel + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign col     = r_col;
  assign row     = r_row;
  assign sel     = r_sel;
  assign addr    = r_addr;
  assign row_end = (r_col == C_COL_LAST);

endmodule
`default_nettype wire

// File: rtl/rb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rb_frame_sequencer
// Purpose  : Frame controller for the row-buffer BRAM datapath. Primes K-1
//            row buffers from external memory, then streams one K-row column
//            per beat while recycling the oldest buffer, with throttling.
// Revision : 1.0 - initial release
// ============================================================================
module rb_frame_sequencer
  import rb_frame_sequencer_pkg::*;
#(
  parameter  int K      = DEF_K,
  parameter  int IMG_W  = DEF_IMG_W,
  parameter  int IMG_H  = DEF_IMG_H,
  localparam int COL_W  = $clog2(IMG_W),
  localparam int ROW_W  = $clog2(IMG_H),
  localparam int SEL_W  = sel_width(K),
  localparam int EMEM_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              e_mem_en,
  output logic [EMEM_W-1:0] e_mem_addr,
  output logic              w_bram_en,
  output logic [COL_W-1:0]  w_bram_addr,
  output logic [SEL_W-1:0]  w_bram_sel,
  output logic              r_bram_en,
  output logic [COL_W-1:0]  r_bram_addr,
  output logic [SEL_W-1:0]  steer,
  output logic              steer_en,
  output logic              win_valid
);

  localparam logic [ROW_W-1:0] C_ROW_PRIME_LAST = ROW_W'(K - 2);
  localparam logic [ROW_W-1:0] C_ROW_LAST       = ROW_W'(IMG_H - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_win_valid;

  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic [SEL_W-1:0]  w_sel;
  logic [EMEM_W-1:0] w_addr;
  logic              w_row_end;

  logic              w_prime;
  logic              w_stream_beat;
  logic              w_prime_end;
  logic              w_last_beat;
  logic              w_advance;

  assign w_prime       = (r_state == C_ST_PRIME);
  assign w_stream_beat = (r_state == C_ST_STREAM) && out_ready;
  // Last priming beat fills the final buffer; counter wrap already leaves sel=0, row=K-1
  assign w_prime_end   = w_prime && w_row_end && (w_row == C_ROW_PRIME_LAST);
  assign w_last_beat   = w_stream_beat && w_row_end && (w_row == C_ROW_LAST);
  assign w_advance     = w_prime || w_stream_beat;

  rb_raster_counter #(
    .IMG_W  (IMG_W),
    .K      (K),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W),
    .SEL_W  (SEL_W),
    .EMEM_W (EMEM_W)
  ) u_raster (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_last_beat),
    .advance (w_advance),
    .col     (w_col),
    .row     (w_row),
    .sel     (w_sel),
    .addr    (w_addr),
    .row_end (w_row_end)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; start only matters in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_ST_IDLE:   if (start)       w_next_state = C_ST_PRIME;
      C_ST_PRIME:  if (w_prime_end) w_next_state = C_ST_STREAM;
      C_ST_STREAM: if (w_last_beat) w_next_state = C_ST_DONE;
      C_ST_DONE:                    w_next_state = C_ST_IDLE;
      default:                      w_next_state = C_ST_IDLE;
    endcase
  end

  // Output decode; out_ready gates only the streaming enables
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    e_mem_en  = 1'b0;
    w_bram_en = 1'b0;
    r_bram_en = 1'b0;
    steer_en  = 1'b0;
    steer     = '0;
    case (r_state)
      C_ST_PRIME: begin
        busy      = 1'b1;
        e_mem_en  = 1'b1;
        w_bram_en = 1'b1;
      end
      C_ST_STREAM: begin
        busy      = 1'b1;
        steer     = w_sel;
        e_mem_en  = out_ready;
        w_bram_en = out_ready;
        r_bram_en = out_ready;
        steer_en  = out_ready;
      end
      C_ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign e_mem_addr  = w_addr;
  assign w_bram_addr = w_col;
  assign r_bram_addr = w_col;
  assign w_bram_sel  = w_sel;

  // Window valid follows each issued stream beat by one cycle, matching BRAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_valid <= 1'b0;
    end else begin
      r_win_valid <= w_stream_beat;
    end
  end

  assign win_valid = r_win_valid;

endmodule
`default_nettype wire

// File: tb/tb_rb_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rb_frame_sequencer
// Purpose  : Self-checking bench for rb_frame_sequencer (K=3 4x4 main DUT,
//            K=2 3x3 secondary DUT) against a raster-order frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rb_frame_sequencer;

  localparam int K = 3;
  localparam int W = 4;
  localparam int H = 4;
  localparam int P = (K - 1) * W;   // priming beats
  localparam int N = W * H;         // total beats per frame

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic busy, done, e_mem_en, w_bram_en, r_bram_en, steer_en, win_valid;
  logic [3:0] e_mem_addr;
  logic [1:0] w_bram_addr, r_bram_addr;
  logic [0:0] w_bram_sel, steer;

  logic start2, out_ready2;
  logic d2_busy, d2_done, d2_e_mem_en, d2_w_bram_en, d2_r_bram_en, d2_steer_en, d2_win_valid;
  logic [3:0] d2_e_mem_addr;
  logic [1:0] d2_w_bram_addr, d2_r_bram_addr;
  logic [0:0] d2_w_bram_sel, d2_steer;

  always #5 clk = ~clk;

  rb_frame_sequencer #(.K(K), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
    .busy(busy), .done(done), .e_mem_en(e_mem_en), .e_mem_addr(e_mem_addr),
    .w_bram_en(w_bram_en), .w_bram_addr(w_bram_addr), .w_bram_sel(w_bram_sel),
    .r_bram_en(r_bram_en), .r_bram_addr(r_bram_addr),
    .steer(steer), .steer_en(steer_en), .win_valid(win_valid)
  );

  rb_frame_sequencer #(.K(2), .IMG_W(3), .IMG_H(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .out_ready(out_ready2),
    .busy(d2_busy), .done(d2_done), .e_mem_en(d2_e_mem_en), .e_mem_addr(d2_e_mem_addr),
    .w_bram_en(d2_w_bram_en), .w_bram_addr(d2_w_bram_addr), .w_bram_sel(d2_w_bram_sel),
    .r_bram_en(d2_r_bram_en), .r_bram_addr(d2_r_bram_addr),
    .steer(d2_steer), .steer_en(d2_steer_en), .win_valid(d2_win_valid)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int wv_cnt, done_cnt;
  bit exp_wv;
  logic [16:0] m_all, m_prime, m_stall, m_done;

  function automatic logic [16:0] pk(input logic b, input logic d, input logic een,
                                     input logic [3:0] ea, input logic wen,
                                     input logic [1:0] wa, input logic ws, input logic ren,
                                     input logic [1:0] ra, input logic st,
                                     input logic sten, input logic wv);
    return {b, d, een, ea, wen, wa, ws, ren, ra, st, sten, wv};
  endfunction

  task automatic check(input string tag, input logic [16:0] exp, input logic [16:0] msk);
    logic [16:0] a;
    a = pk(busy, done, e_mem_en, e_mem_addr, w_bram_en, w_bram_addr, w_bram_sel,
           r_bram_en, r_bram_addr, steer, steer_en, win_valid);
    n_assert++;
    assert ((a & msk) === (exp & msk)) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, a & msk, exp & msk);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, then drive next inputs just after posedge
  task automatic cyc(input string tag, input logic [16:0] exp, input logic [16:0] msk);
    @(negedge clk);
    check(tag, exp, msk);
    if (win_valid) wv_cnt++;
    if (done) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Frame model: beat i is pixel (i/W, i%W); buffer index for row r is r%(K-1)
  task automatic run_frame(input string name, input int stall_pct, input int force_i,
                           input int force_len, input bit keep_start, input int abort_i);
    int nst, row, col, sel;
    bit strm;
    logic [16:0] bexp;
    wv_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    cyc({name, " idle"}, pk(0,0,0,4'h0,0,2'h0,0,0,2'h0,0,0,exp_wv), m_all);
    exp_wv = 1'b0;
    if (!keep_start) start = 1'b0;
    for (int i = 0; i < N; i++) begin
      row = i / W;
      col = i % W;
      sel = row % (K - 1);
      strm = (i >= P);
      if (strm) begin
        if (i == force_i) nst = force_len;
        else if (int'($urandom_range(0, 99)) < stall_pct) nst = int'($urandom_range(1, 3));
        else nst = 0;
        for (int s = 0; s < nst; s++) begin
          out_ready = 1'b0;
          cyc({name, " stall"}, pk(1,0,0,4'(i),0,2'(col),1'(sel),0,2'(col),1'(sel),0,exp_wv), m_stall);
          exp_wv = 1'b0;
        end
        out_ready = 1'b1;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      bexp = pk(1,0,1,4'(i),1,2'(col),1'(sel),strm,2'(col),1'(sel),strm,exp_wv);
      if (i == abort_i) begin
        @(negedge clk);
        check({name, " beat before rst"}, bexp, m_all);
        #2 rst = 1'b1;
        #1 check({name, " async rst"}, '0, m_all);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b0;
        exp_wv = 1'b0;
        return;
      end
      cyc(strm ? {name, " stream beat"} : {name, " prime beat"}, bexp, strm ? m_all : m_prime);
      exp_wv = strm;
    end
    out_ready = 1'($urandom_range(0, 1));
    cyc({name, " done"}, pk(1,1,0,4'h0,0,2'h0,0,0,2'h0,0,0,exp_wv), m_done);
    exp_wv = 1'b0;
    check_int({name, " win_valid count"}, wv_cnt, N - P);
    check_int({name, " done pulses"}, done_cnt, 1);
  endtask

  initial begin
    int p2, s2, bad2, done_at, e2_next, wv2;
    m_all   = '1;
    m_prime = pk(1,1,1,4'hF,1,2'h3,1,1,2'h0,0,1,1);
    m_stall = pk(1,1,1,4'hF,1,2'h0,0,1,2'h3,1,1,1);
    m_done  = pk(1,1,1,4'h0,1,2'h0,0,1,2'h0,0,1,1);
    exp_wv = 1'b0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    start2 = 1'b0; out_ready2 = 1'b1;

    @(negedge clk);
    check("reset state", '0, m_all);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc("idle after reset", '0, m_all);

    run_frame("full rate", 0, -1, 0, 1'b0, -1);
    cyc("idle after frame", '0, m_all);
    run_frame("stall row2", 0, P + 1, 3, 1'b0, -1);
    cyc("idle after stall", '0, m_all);
    run_frame("random stall", 35, -1, 0, 1'b0, -1);
    run_frame("aborted", 0, -1, 0, 1'b0, P + 3);
    cyc("idle after abort", '0, m_all);
    run_frame("after abort", 20, -1, 0, 1'b0, -1);
    run_frame("b2b first", 0, -1, 0, 1'b1, -1);
    run_frame("b2b second", 0, -1, 0, 1'b0, -1);
    cyc("final idle", '0, m_all);

    // Secondary geometry: K=2, 3x3 -> 3 priming, 6 streaming, done 10 cycles after start
    p2 = 0; s2 = 0; bad2 = 0; done_at = -1; e2_next = 0; wv2 = 0;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (d2_w_bram_en && !d2_r_bram_en) p2++;
      if (d2_r_bram_en) s2++;
      if (d2_win_valid) wv2++;
      if (d2_w_bram_en && d2_w_bram_sel != 1'b0) bad2++;
      if (d2_steer_en && d2_steer != 1'b0) bad2++;
      if (d2_r_bram_en && d2_r_bram_addr != d2_w_bram_addr) bad2++;
      if (d2_e_mem_en) begin
        if (int'(d2_e_mem_addr) != e2_next) bad2++;
        e2_next++;
      end
      if (d2_done && done_at < 0) begin
        done_at = c;
        if (!d2_busy) bad2++;
      end
      @(posedge clk);
      #1;
      if (done_at >= 0) break;
    end
    @(negedge clk);
    if (d2_win_valid) wv2++;
    check_int("k2 prime cycles", p2, 3);
    check_int("k2 stream beats", s2, 6);
    check_int("k2 done cycle", done_at, 10);
    check_int("k2 addr count", e2_next, 9);
    check_int("k2 win_valid count", wv2, 6);
    check_int("k2 sel/addr errors", bad2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
